// File: rtl/vending_machine_multi_pkg.sv
// vm_pkg: shared coin codes, coin values and FSM states for the multi-product vending machine
// Exports: coin_e, state_e, COIN_VAL_* constants, coin_value(code)
package vm_pkg;
    localparam int COIN_VAL_W = 8;
    localparam logic [COIN_VAL_W-1:0] COIN_VAL_1 = 8'd1;
    localparam logic [COIN_VAL_W-1:0] COIN_VAL_2 = 8'd2;
    localparam logic [COIN_VAL_W-1:0] COIN_VAL_5 = 8'd5;

    typedef enum logic [1:0] {COIN_NONE, COIN_1, COIN_2, COIN_5} coin_e;
    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_e;

    function automatic logic [COIN_VAL_W-1:0] coin_value(input coin_e code);
        return code == COIN_5 ? COIN_VAL_5 :
               code == COIN_2 ? COIN_VAL_2 :
               code == COIN_1 ? COIN_VAL_1 : '0;
    endfunction
endpackage

// File: rtl/vending_machine_multi_change_pick.sv
// vm_change_pick: picks the largest coin not exceeding the given credit
// Ports: credit_i (credit to pay from), coin_o (coin code, COIN_NONE when credit is 0), value_o (its value)
module vm_change_pick
    import vm_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] credit_i,
    output coin_e               coin_o,
    output logic [CREDIT_W-1:0] value_o
);
    always_comb begin
        coin_o  = credit_i >= CREDIT_W'(COIN_VAL_5) ? COIN_5 :
                  credit_i >= CREDIT_W'(COIN_VAL_2) ? COIN_2 :
                  credit_i >= CREDIT_W'(COIN_VAL_1) ? COIN_1 : COIN_NONE;
        value_o = CREDIT_W'(coin_value(coin_o));
    end
endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-product vending FSM with credit, vend handshake and coin-by-coin change
// Ports: clk, rst (async active-low); coin/sel_valid/sel_item/cancel/stock_empty from the front-end;
//        vend_valid/vend_item/vend_ready to the dispenser; change_valid/change_coin/change_ready to the hopper;
//        credit, coin_reject, sel_error, busy status (all registered)
module vending_machine_multi
    import vm_pkg::*;
#(
    parameter int                          N_ITEMS    = 4,
    parameter int                          CREDIT_W   = 8,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = {8'd10, 8'd7, 8'd5, 8'd3},
    parameter int                          MAX_CREDIT = 20,
    localparam int                         IW         = $clog2(N_ITEMS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [IW-1:0]       sel_item,
    input  logic                cancel,
    input  logic [N_ITEMS-1:0]  stock_empty,
    output logic                vend_valid,
    output logic [IW-1:0]       vend_item,
    input  logic                vend_ready,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_error,
    output logic                busy
);
    state_e              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic                vend_valid_q;
    logic [IW-1:0]       vend_item_q;
    logic                change_valid_q;
    coin_e               change_coin_q;
    logic                coin_reject_q;
    logic                sel_error_q;

    logic [CREDIT_W-1:0] price, coin_val, cred_after, pick_in, pick_val;
    logic [CREDIT_W:0]   coin_sum;
    coin_e               pick_code;
    logic                in_range, sold_out, can_take, sel_ok, sel_bad, coin_ok;

    // Out-of-range indices leave in_range low, so the selection is refused.
    always_comb begin
        price    = '0;
        sold_out = 1'b0;
        in_range = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel_item == IW'(i)) begin
                price    = PRICES[i*CREDIT_W +: CREDIT_W];
                sold_out = stock_empty[i];
                in_range = 1'b1;
            end
        end
    end

    // A cancel strobe outranks selection and coin even in IDLE, where it has no other effect.
    assign can_take   = state_q == IDLE || state_q == COLLECT;
    assign sel_ok     = can_take && !cancel && sel_valid && in_range && !sold_out && credit_q >= price;
    assign sel_bad    = can_take && !cancel && sel_valid && !sel_ok;
    assign coin_val   = CREDIT_W'(coin_value(coin_e'(coin)));
    assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_ok    = can_take && !cancel && !sel_ok && coin != 2'b00 &&
                        coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
    assign cred_after = credit_q - CREDIT_W'(coin_value(change_coin_q));

    // In CHANGE the picker looks ahead at the credit left after the current coin,
    // so the next coin is ready in the register the cycle after the handshake.
    assign pick_in = state_q == CHANGE ? cred_after : credit_q;

    vm_change_pick #(.CREDIT_W(CREDIT_W)) u_pick (
        .credit_i (pick_in),
        .coin_o   (pick_code),
        .value_o  (pick_val)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            vend_valid_q   <= 1'b0;
            vend_item_q    <= '0;
            change_valid_q <= 1'b0;
            change_coin_q  <= COIN_NONE;
            coin_reject_q  <= 1'b0;
            sel_error_q    <= 1'b0;
        end else begin
            coin_reject_q <= coin != 2'b00 && !coin_ok;
            sel_error_q   <= sel_bad;
            case (state_q)
                IDLE, COLLECT: begin
                    if (cancel) begin
                        if (state_q == COLLECT) begin
                            state_q        <= CHANGE;
                            change_valid_q <= 1'b1;
                            change_coin_q  <= pick_code;
                        end
                    end else if (sel_ok) begin
                        credit_q     <= credit_q - price;
                        vend_item_q  <= sel_item;
                        vend_valid_q <= 1'b1;
                        state_q      <= VEND;
                    end else if (coin_ok) begin
                        credit_q <= coin_sum[CREDIT_W-1:0];
                        state_q  <= COLLECT;
                    end
                end
                VEND: begin
                    if (vend_ready) begin
                        vend_valid_q <= 1'b0;
                        if (credit_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            state_q        <= CHANGE;
                            change_valid_q <= 1'b1;
                            change_coin_q  <= pick_code;
                        end
                    end
                end
                CHANGE: begin
                    if (change_ready) begin
                        credit_q <= cred_after;
                        if (pick_val == '0) begin
                            change_valid_q <= 1'b0;
                            change_coin_q  <= COIN_NONE;
                            state_q        <= IDLE;
                        end else begin
                            change_coin_q <= pick_code;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign credit       = credit_q;
    assign vend_valid   = vend_valid_q;
    assign vend_item    = vend_item_q;
    assign change_valid = change_valid_q;
    assign change_coin  = change_coin_q;
    assign coin_reject  = coin_reject_q;
    assign sel_error    = sel_error_q;
    assign busy         = state_q == VEND || state_q == CHANGE;
endmodule

// File: tb/tb_vending_machine_multi.sv
// tb_vending_machine_multi: directed scenarios plus randomized run against a credit/coin-queue model
module tb_vending_machine_multi;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] coin = '0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_item = '0;
    logic       cancel = 1'b0;
    logic [3:0] stock_empty = '0;
    logic       vend_valid;
    logic [1:0] vend_item;
    logic       vend_ready = 1'b0;
    logic       change_valid;
    logic [1:0] change_coin;
    logic       change_ready = 1'b0;
    logic [7:0] credit;
    logic       coin_reject;
    logic       sel_error;
    logic       busy;

    int checks = 0;
    int errors = 0;

    vending_machine_multi dut (
        .clk(clk), .rst(rst), .coin(coin), .sel_valid(sel_valid), .sel_item(sel_item),
        .cancel(cancel), .stock_empty(stock_empty), .vend_valid(vend_valid), .vend_item(vend_item),
        .vend_ready(vend_ready), .change_valid(change_valid), .change_coin(change_coin),
        .change_ready(change_ready), .credit(credit), .coin_reject(coin_reject),
        .sel_error(sel_error), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: credit, pending vend, and the list of change coin values still owed.
    int m_credit;
    bit m_vend;
    int m_item;
    int m_chg[$];
    bit m_rej;
    bit m_serr;
    int prices[4] = '{3, 5, 7, 10};

    function automatic int val_of(input logic [1:0] c);
        return c == 2'd3 ? 5 : int'(c);
    endfunction

    function automatic logic [1:0] code_of(input int v);
        return v == 5 ? 2'd3 : 2'(v);
    endfunction

    task automatic m_fill();
        int c = m_credit;
        while (c > 0) begin
            int v = c >= 5 ? 5 : c >= 2 ? 2 : 1;
            m_chg.push_back(v);
            c -= v;
        end
    endtask

    task automatic m_step(input logic [1:0] c, input bit sv, input int si, input bit cn,
                          input bit vr, input bit cr, input logic [3:0] se);
        m_rej  = 0;
        m_serr = 0;
        if (m_vend) begin
            if (vr) begin
                m_vend = 0;
                m_fill();
            end
            m_rej = c != 0;
        end else if (m_chg.size() > 0) begin
            if (cr) m_credit -= m_chg.pop_front();
            m_rej = c != 0;
        end else if (cn) begin
            if (m_credit > 0) m_fill();
            m_rej = c != 0;
        end else if (sv && !se[si] && m_credit >= prices[si]) begin
            m_credit -= prices[si];
            m_vend = 1;
            m_item = si;
            m_rej  = c != 0;
        end else begin
            m_serr = sv;
            if (c != 0) begin
                if (m_credit + val_of(c) <= 20) m_credit += val_of(c);
                else m_rej = 1;
            end
        end
    endtask

    task automatic tick(input logic [1:0] c = 0, input bit sv = 0, input logic [1:0] si = 0,
                        input bit cn = 0, input bit vr = 0, input bit cr = 0);
        coin = c; sel_valid = sv; sel_item = si; cancel = cn; vend_ready = vr; change_ready = cr;
        @(posedge clk);
        #1;
        coin = 0; sel_valid = 0; cancel = 0; vend_ready = 0; change_ready = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        stock_empty = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if ({vend_valid, change_valid, coin_reject, sel_error, busy} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {vend_valid, change_valid, coin_reject, sel_error, busy}); end
        checks++; if (credit !== 8'd0 || vend_item !== 2'd0 || change_coin !== 2'd0) begin errors++; $display("FAIL reset_values credit=%0d item=%0d coin=%0d want 0", credit, vend_item, change_coin); end
    endtask

    task automatic test_exact_vend();
        apply_reset();
        tick(2'd3);
        checks++; if (credit !== 8'd5) begin errors++; $display("FAIL exact_credit5 got %0d want 5", credit); end
        tick(2'd2);
        checks++; if (credit !== 8'd7) begin errors++; $display("FAIL exact_credit7 got %0d want 7", credit); end
        tick(0, 1, 2'd2);
        checks++; if (vend_valid !== 1'b1 || vend_item !== 2'd2 || credit !== 8'd0 || busy !== 1'b1) begin errors++; $display("FAIL exact_vend vv=%b item=%0d credit=%0d busy=%b want 1/2/0/1", vend_valid, vend_item, credit, busy); end
        tick(0, 0, 0, 0, 1);
        checks++; if (vend_valid !== 1'b0 || change_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL exact_done vv=%b cv=%b busy=%b want 000", vend_valid, change_valid, busy); end
    endtask

    task automatic test_vend_change();
        apply_reset();
        tick(2'd3); tick(2'd3);
        tick(0, 1, 2'd0);
        checks++; if (vend_valid !== 1'b1 || vend_item !== 2'd0 || credit !== 8'd7) begin errors++; $display("FAIL chg_vend vv=%b item=%0d credit=%0d want 1/0/7", vend_valid, vend_item, credit); end
        tick(0, 0, 0, 0, 1);
        checks++; if (change_valid !== 1'b1 || change_coin !== 2'd3 || credit !== 8'd7) begin errors++; $display("FAIL chg_first cv=%b coin=%0d credit=%0d want 1/3/7", change_valid, change_coin, credit); end
        tick(0, 0, 0, 0, 0, 1);
        checks++; if (change_valid !== 1'b1 || change_coin !== 2'd2 || credit !== 8'd2) begin errors++; $display("FAIL chg_second cv=%b coin=%0d credit=%0d want 1/2/2", change_valid, change_coin, credit); end
        tick(0, 0, 0, 0, 0, 1);
        checks++; if (change_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL chg_done cv=%b credit=%0d busy=%b want 0/0/0", change_valid, credit, busy); end
    endtask

    task automatic test_sel_error();
        apply_reset();
        tick(2'd2);
        tick(0, 1, 2'd1);
        checks++; if (sel_error !== 1'b1 || credit !== 8'd2 || vend_valid !== 1'b0) begin errors++; $display("FAIL poor_sel serr=%b credit=%0d vv=%b want 1/2/0", sel_error, credit, vend_valid); end
        tick();
        checks++; if (sel_error !== 1'b0 || vend_valid !== 1'b0) begin errors++; $display("FAIL poor_pulse serr=%b vv=%b want 0/0", sel_error, vend_valid); end
    endtask

    task automatic test_max_credit();
        apply_reset();
        repeat (4) tick(2'd3);
        checks++; if (credit !== 8'd20) begin errors++; $display("FAIL max_fill got %0d want 20", credit); end
        tick(2'd3);
        checks++; if (coin_reject !== 1'b1 || credit !== 8'd20) begin errors++; $display("FAIL max_reject rej=%b credit=%0d want 1/20", coin_reject, credit); end
        tick();
        checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL max_pulse rej=%b want 0", coin_reject); end
        tick(0, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            checks++; if (change_valid !== 1'b1 || change_coin !== 2'd3 || credit !== 8'(20 - 5*k)) begin errors++; $display("FAIL max_coin%0d cv=%b coin=%0d credit=%0d want 1/3/%0d", k, change_valid, change_coin, credit, 20 - 5*k); end
            tick(0, 0, 0, 0, 0, 1);
        end
        checks++; if (change_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL max_done cv=%b credit=%0d busy=%b want 0/0/0", change_valid, credit, busy); end
    endtask

    task automatic test_stock_empty();
        apply_reset();
        tick(2'd3); tick(2'd3);
        stock_empty = 4'b1000;
        tick(0, 1, 2'd3);
        checks++; if (sel_error !== 1'b1 || vend_valid !== 1'b0 || credit !== 8'd10) begin errors++; $display("FAIL stock_refuse serr=%b vv=%b credit=%0d want 1/0/10", sel_error, vend_valid, credit); end
        stock_empty = 4'b0000;
        tick(0, 1, 2'd3);
        checks++; if (vend_valid !== 1'b1 || vend_item !== 2'd3 || credit !== 8'd0 || sel_error !== 1'b0) begin errors++; $display("FAIL stock_vend vv=%b item=%0d credit=%0d serr=%b want 1/3/0/0", vend_valid, vend_item, credit, sel_error); end
        tick(2'd1, 1, 2'd0, 1);
        checks++; if (vend_valid !== 1'b1 || coin_reject !== 1'b1 || sel_error !== 1'b0 || credit !== 8'd0) begin errors++; $display("FAIL vend_ignore vv=%b rej=%b serr=%b credit=%0d want 1/1/0/0", vend_valid, coin_reject, sel_error, credit); end
        tick(0, 0, 0, 0, 1);
    endtask

    task automatic test_hold_and_async_reset();
        apply_reset();
        tick(2'd3); tick(2'd2);
        tick(0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            checks++; if (change_valid !== 1'b1 || change_coin !== 2'd3 || credit !== 8'd7) begin errors++; $display("FAIL hold%0d cv=%b coin=%0d credit=%0d want 1/3/7", k, change_valid, change_coin, credit); end
            tick(2'd1, 1, 2'd0, 1, 0, 0);
        end
        rst = 1'b0;
        #1;
        checks++; if ({vend_valid, change_valid, coin_reject, sel_error, busy} !== 5'b0 || credit !== 8'd0 || change_coin !== 2'd0) begin errors++; $display("FAIL async_rst flags=%b credit=%0d coin=%0d want 0", {vend_valid, change_valid, coin_reject, sel_error, busy}, credit, change_coin); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || credit !== 8'd0 || change_valid !== 1'b0) begin errors++; $display("FAIL post_rst busy=%b credit=%0d cv=%b want 0/0/0", busy, credit, change_valid); end
    endtask

    task automatic test_random();
        apply_reset();
        m_credit = 0; m_vend = 0; m_item = 0; m_chg.delete();
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] c  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            bit         sv = $urandom_range(0, 4) == 0;
            logic [1:0] si = 2'($urandom_range(0, 3));
            bit         cn = $urandom_range(0, 11) == 0;
            bit         vr = $urandom_range(0, 1) == 1;
            bit         cr = $urandom_range(0, 1) == 1;
            logic [1:0] ec;
            logic [3:0] se;
            if ($urandom_range(0, 19) == 0) stock_empty = 4'($urandom_range(0, 15));
            se = stock_empty;
            tick(c, sv, si, cn, vr, cr);
            m_step(c, sv, int'(si), cn, vr, cr, se);
            ec = m_chg.size() > 0 ? code_of(m_chg[0]) : 2'd0;
            checks++; if (credit !== 8'(m_credit)) begin errors++; $display("FAIL rnd_credit n=%0d got %0d want %0d", n, credit, m_credit); end
            checks++; if (vend_valid !== m_vend || (m_vend && vend_item !== 2'(m_item))) begin errors++; $display("FAIL rnd_vend n=%0d vv=%b item=%0d want %b/%0d", n, vend_valid, vend_item, m_vend, m_item); end
            checks++; if (change_valid !== (m_chg.size() > 0) || (change_valid && change_coin !== ec)) begin errors++; $display("FAIL rnd_change n=%0d cv=%b coin=%0d want %b/%0d", n, change_valid, change_coin, m_chg.size() > 0, ec); end
            checks++; if (coin_reject !== m_rej || sel_error !== m_serr) begin errors++; $display("FAIL rnd_pulses n=%0d rej=%b serr=%b want %b/%b", n, coin_reject, sel_error, m_rej, m_serr); end
            checks++; if (busy !== (m_vend || m_chg.size() > 0)) begin errors++; $display("FAIL rnd_busy n=%0d got %b", n, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_exact_vend();
        test_vend_change();
        test_sel_error();
        test_max_credit();
        test_stock_empty();
        test_hold_and_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
- Parametrised successor to the single-product vending FSM.
- Accumulates credit from a 2-bit coin input and serves N_ITEMS products with per-item prices and stock-empty inputs.
- Hands off vends to a dispenser over a valid/ready handshake, then pays out change one coin at a time, largest coin first, over a second valid/ready handshake.
- Sits between the coin acceptor front-end and the dispenser/hopper drivers.

Parameters:
- N_ITEMS, 4, number of selectable products (2..16).
- CREDIT_W, 8, width of the credit register and of each price.
- PRICES, {8'd10,8'd7,8'd5,8'd3}, packed N_ITEMS*CREDIT_W price vector; item 0 in the LSBs.
- MAX_CREDIT, 20, highest credit accepted; must be ≤ 2**CREDIT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- coin  in  2  one-cycle coin event: 00 none, 01 = 1 unit, 10 = 2 units, 11 = 5 units.
- sel_valid  in  1  one-cycle product selection strobe.
- sel_item  in  $clog2(N_ITEMS)  selected item index.
- cancel  in  1  one-cycle refund request.
- stock_empty  in  N_ITEMS  per-item sold-out flags.
- vend_valid  out  1  dispense request.
- vend_item  out  $clog2(N_ITEMS)  item to dispense; stable while vend_valid.
- vend_ready  in  1  dispenser accept.
- change_valid  out  1  change coin request.
- change_coin  out  2  coin code to eject; stable while change_valid.
- change_ready  in  1  hopper accept.
- credit  out  CREDIT_W  current credit, registered.
- coin_reject  out  1  one-cycle pulse: the coin was not credited.
- sel_error  out  1  one-cycle pulse: the selection was refused.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. credit, vend_valid, vend_item, change_valid, change_coin, coin_reject, sel_error and busy all go to 0. Any in-flight vend or change is abandoned without completion.
- All outputs are registered. Every decision uses the registered credit value. Effects appear one cycle after the input strobe.
- States: IDLE (credit==0), COLLECT (credit>0), VEND, CHANGE.
- Priority within a single cycle in IDLE or COLLECT: cancel > sel_valid > coin.
- Coin handling (IDLE or COLLECT, no cancel and no accepted selection this cycle):
  - If credit+value ≤ MAX_CREDIT: credit += value; IDLE→COLLECT.
  - Otherwise: coin_reject pulses and credit is unchanged.
- Coins are always rejected (coin_reject pulse) in these cases:
  - In VEND or CHANGE.
  - In the same cycle as an accepted cancel or selection.
- Selection (IDLE or COLLECT):
  - If stock_empty[sel_item]=1, or sel_item ≥ N_ITEMS, or credit < PRICES[sel_item]: sel_error pulses and state/credit are unchanged.
  - Otherwise: credit -= price, latch vend_item, assert vend_valid, go to VEND.
- VEND:
  - vend_valid stays high until the cycle with vend_ready=1.
  - On that handshake, vend_valid drops next cycle. Then credit==0 → IDLE, else → CHANGE.
  - sel_valid and cancel are ignored in VEND.
- Cancel:
  - In COLLECT: go to CHANGE.
  - In IDLE: no effect.
- CHANGE:
  - change_coin = largest coin ≤ credit (5, then 2, then 1); change_valid=1.
  - On a change_valid & change_ready cycle: credit -= coin value. The next coin is presented the following cycle; change_valid remains high while credit > 0.
  - When credit reaches 0: change_valid drops and state goes to IDLE.
  - change_ready=0 holds the current coin stable indefinitely.
  - Inputs other than rst are ignored in CHANGE.
- Credit never goes negative and never exceeds MAX_CREDIT.
- Subtraction uses CREDIT_W bits; the width is sufficient because price ≤ credit is checked before subtracting.

Decomposition:
- Package vm_pkg holds:
  - the coin-code enum (COIN_NONE, COIN_1, COIN_2, COIN_5);
  - the coin value constants 1/2/5;
  - the state enum (IDLE, COLLECT, VEND, CHANGE);
  - a function coin_value(code) returning CREDIT_W bits.
- One sub-module, vm_change_pick: combinational; takes credit and returns the largest coin code ≤ credit and its value. Used by the CHANGE state.

Test Plan (default parameters):
- After reset, insert 5, then 2 (credit=7); select item 2 → next cycle vend_valid=1, vend_item=2, credit=0. Pulse vend_ready → IDLE, change_valid never asserted.
- Insert 5, 5; select item 0 (price 3) → vend handshake, then change_coin=11 (5), then 10 (2), with change_ready held high. credit goes 7→2→0, then IDLE.
- Credit 2, select item 1 (price 5) → sel_error pulses once; credit stays 2; vend_valid stays 0.
- Insert 5 four times (credit=20), then a fifth 5 → coin_reject pulses, credit=20. Cancel → four change coins of code 11, then IDLE.
- Credit 10, stock_empty[3]=1, select item 3 → sel_error. Then clear stock_empty and select item 3 → vend, credit=0.
- In CHANGE with change_ready=0 for 5 cycles → change_coin stays stable and credit is unchanged. Drive rst=0 mid-CHANGE → all outputs 0 asynchronously; after release the block is in IDLE with credit=0.
